// File: rtl/ph_tx_credit_gate.sv
// Transmit-side Posted Header credit gate: tracks advertised limit vs. consumed
// credits with modulo-2^W arithmetic, and flags type, limit and starvation errors.
module ph_tx_credit_gate #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [2:0]  BUFFER_TYPE    = 3'b000,
    parameter int unsigned REQ_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fc_update_valid,
    input  logic [DATA_WIDTH+2:0] credit_limit,
    input  logic                  tlp_valid,
    input  logic [REQ_WIDTH-1:0]  tlp_credits,
    output logic                  tlp_ready,
    output logic [DATA_WIDTH-1:0] credits_consumed,
    output logic [DATA_WIDTH-1:0] credits_available,
    output logic                  fc_init_done,
    output logic                  fc_infinite,
    output logic                  type_error,
    output logic                  limit_error,
    output logic                  fc_timeout
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]     HALF_RANGE = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_INIT,
        ST_ACTIVE
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     limit_q, limit_d;
    logic [W-1:0]     consumed_q, consumed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic             infinite_q, infinite_d;
    logic             type_err_q, type_err_d;
    logic             limit_err_q, limit_err_d;

    logic             active;
    logic             type_ok;
    logic             upd_match;
    logic             upd_accept;
    logic             transfer;
    logic [W-1:0]     req_ext;
    logic [W-1:0]     headroom;
    logic [W-1:0]     upd_limit;
    logic [W-1:0]     upd_delta;

    // A result within half the counter range is treated as "not past the limit".
    assign active    = (state_q == ST_ACTIVE);
    assign req_ext   = W'(tlp_credits);
    assign headroom  = limit_q - (consumed_q + req_ext);
    assign upd_limit = credit_limit[W-1:0];
    assign upd_delta = upd_limit - limit_q;
    assign type_ok   = (credit_limit[W+2:W] == BUFFER_TYPE);
    assign upd_match = fc_update_valid & type_ok;
    assign tlp_ready = active & (infinite_q | (headroom <= HALF_RANGE));
    assign transfer  = tlp_valid & tlp_ready;

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        consumed_d  = consumed_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        infinite_d  = infinite_q;
        type_err_d  = type_err_q | (fc_update_valid & ~type_ok);
        limit_err_d = limit_err_q;
        upd_accept  = 1'b0;

        case (state_q)
            ST_INIT: begin
                cnt_d = '0;
                if (upd_match) begin
                    limit_d     = upd_limit;
                    infinite_d  = (upd_limit == '0);
                    init_done_d = 1'b1;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (transfer) begin
                    consumed_d = consumed_q + req_ext;
                end
                // Infinite credit mode freezes the limit for good.
                if (upd_match && !infinite_q) begin
                    if (upd_delta <= HALF_RANGE) begin
                        limit_d    = upd_limit;
                        upd_accept = 1'b1;
                    end else begin
                        limit_err_d = 1'b1;
                    end
                end
                if (transfer || upd_accept || !tlp_valid) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            limit_q     <= '0;
            consumed_q  <= '0;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            infinite_q  <= 1'b0;
            type_err_q  <= 1'b0;
            limit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            consumed_q  <= consumed_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            infinite_q  <= infinite_d;
            type_err_q  <= type_err_d;
            limit_err_q <= limit_err_d;
        end
    end

    assign credits_consumed  = consumed_q;
    assign credits_available = !active   ? '0 :
                               infinite_q ? '1 : (limit_q - consumed_q);
    assign fc_init_done      = init_done_q;
    assign fc_infinite       = infinite_q;
    assign type_error        = type_err_q;
    assign limit_error       = limit_err_q;
    assign fc_timeout        = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ph_tx_credit_gate.sv
// Bench for ph_tx_credit_gate: directed scenarios plus a randomized run against
// an integer-arithmetic credit model.
module tb_ph_tx_credit_gate;

    localparam int W    = 8;
    localparam int MOD  = 256;
    localparam int HALF = 128;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          fc_update_valid;
    logic [W+2:0]  credit_limit;
    logic          tlp_valid;
    logic [3:0]    tlp_credits;
    logic          tlp_ready;
    logic [W-1:0]  credits_consumed;
    logic [W-1:0]  credits_available;
    logic          fc_init_done;
    logic          fc_infinite;
    logic          type_error;
    logic          limit_error;
    logic          fc_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_active, m_inf, m_type_err, m_limit_err;
    int m_limit, m_cons, m_cnt;

    ph_tx_credit_gate #(
        .DATA_WIDTH    (8),
        .BUFFER_TYPE   (3'b000),
        .REQ_WIDTH     (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fc_update_valid  (fc_update_valid),
        .credit_limit     (credit_limit),
        .tlp_valid        (tlp_valid),
        .tlp_credits      (tlp_credits),
        .tlp_ready        (tlp_ready),
        .credits_consumed (credits_consumed),
        .credits_available(credits_available),
        .fc_init_done     (fc_init_done),
        .fc_infinite      (fc_infinite),
        .type_error       (type_error),
        .limit_error      (limit_error),
        .fc_timeout       (fc_timeout)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        if (!m_active) return 1'b0;
        if (m_inf) return 1'b1;
        return ((m_limit - m_cons - int'(tlp_credits)) & (MOD - 1)) <= HALF;
    endfunction

    function automatic int m_avail();
        if (!m_active) return 0;
        if (m_inf) return MOD - 1;
        return (m_limit - m_cons) & (MOD - 1);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        bit rdy, xfer, match, acc;
        int lim, delta;
        rdy   = m_ready();
        xfer  = tlp_valid && rdy;
        lim   = int'(credit_limit[W-1:0]);
        match = fc_update_valid && (credit_limit[W+2:W] == 3'b000);
        acc   = 1'b0;
        if (rst) begin
            m_active = 0; m_inf = 0; m_type_err = 0; m_limit_err = 0;
            m_limit = 0; m_cons = 0; m_cnt = 0;
            return;
        end
        if (fc_update_valid && !match) m_type_err = 1;
        if (!m_active) begin
            if (match) begin
                m_limit = lim; m_inf = (lim == 0); m_active = 1;
            end
        end else begin
            if (xfer) m_cons = (m_cons + int'(tlp_credits)) % MOD;
            if (match && !m_inf) begin
                delta = (lim - m_limit) & (MOD - 1);
                if (delta <= HALF) begin
                    m_limit = lim; acc = 1;
                end else begin
                    m_limit_err = 1;
                end
            end
            if (xfer || acc || !tlp_valid) m_cnt = 0;
            else if (m_cnt < TMO) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int c, bit uv, logic [2:0] ut, int ul);
        tlp_valid       = v;
        tlp_credits     = 4'(c);
        fc_update_valid = uv;
        credit_limit    = {ut, 8'(ul)};
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive(0, 0, 0, 3'd0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 3'd0, 16);
        tick();
        tick();
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", tlp_ready); end
        checks++; if (fc_init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", fc_init_done); end
        checks++; if (fc_infinite !== 1'b0) begin errors++; $display("FAIL reset_infinite: got %b want 0", fc_infinite); end
        checks++; if (type_error !== 1'b0 || limit_error !== 1'b0) begin errors++; $display("FAIL reset_errors: got %b%b want 00", type_error, limit_error); end
        checks++; if (fc_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", fc_timeout); end
        checks++; if (credits_available !== 8'd0 || credits_consumed !== 8'd0) begin errors++; $display("FAIL reset_counts: got avail %0d cons %0d want 0 0", credits_available, credits_consumed); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(0, 0, 1, 3'd0, 16);
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (fc_init_done !== 1'b1) begin errors++; $display("FAIL basic_init_done: got %b want 1", fc_init_done); end
        checks++; if (credits_available !== 8'd16) begin errors++; $display("FAIL basic_avail: got %0d want 16", credits_available); end
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 3'd0, 0);
            checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %b want 1", i, tlp_ready); end
            tick();
        end
        checks++; if (credits_consumed !== 8'd16) begin errors++; $display("FAIL basic_consumed: got %0d want 16", credits_consumed); end
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL basic_17th_ready: got %b want 0", tlp_ready); end
        checks++; if (credits_available !== 8'd0) begin errors++; $display("FAIL basic_avail_zero: got %0d want 0", credits_available); end
    endtask

    task automatic test_limit_update();
        drive(1, 1, 1, 3'd0, 20);
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL upd_same_cycle_ready: got %b want 0", tlp_ready); end
        tick();
        drive(1, 1, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL upd_ready[%0d]: got %b want 1", i, tlp_ready); end
            tick();
        end
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL upd_5th_ready: got %b want 0", tlp_ready); end
        checks++; if (credits_consumed !== 8'd20) begin errors++; $display("FAIL upd_consumed: got %0d want 20", credits_consumed); end
        drive(0, 0, 0, 3'd0, 0);
    endtask

    task automatic test_wrap();
        pulse_reset();
        drive(0, 0, 1, 3'd0, 120);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1, 8, 0, 3'd0, 0);
            checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL wrap_a_ready[%0d]: got %b want 1", i, tlp_ready); end
            tick();
        end
        drive(0, 0, 1, 3'd0, 240);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1, 8, 0, 3'd0, 0);
            checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL wrap_b_ready[%0d]: got %b want 1", i, tlp_ready); end
            tick();
        end
        drive(0, 0, 1, 3'd0, 250);
        tick();
        drive(1, 8, 0, 3'd0, 0);
        tick();
        drive(1, 4, 0, 3'd0, 0);
        checks++; if (credits_consumed !== 8'd248) begin errors++; $display("FAIL wrap_consumed248: got %0d want 248", credits_consumed); end
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL wrap_blocked: got %b want 0", tlp_ready); end
        drive(1, 4, 1, 3'd0, 4);
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL wrap_upd_cycle: got %b want 0", tlp_ready); end
        tick();
        drive(1, 4, 0, 3'd0, 0);
        checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL wrap_after_upd: got %b want 1", tlp_ready); end
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (credits_consumed !== 8'd252) begin errors++; $display("FAIL wrap_consumed252: got %0d want 252", credits_consumed); end
        checks++; if (credits_available !== 8'd8) begin errors++; $display("FAIL wrap_avail: got %0d want 8", credits_available); end
        checks++; if (limit_error !== 1'b0) begin errors++; $display("FAIL wrap_limit_err: got %b want 0", limit_error); end
    endtask

    task automatic test_errors();
        pulse_reset();
        drive(0, 0, 1, 3'd0, 20);
        tick();
        drive(0, 0, 1, 3'd1, 30);
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (type_error !== 1'b1) begin errors++; $display("FAIL err_type: got %b want 1", type_error); end
        checks++; if (credits_available !== 8'd20) begin errors++; $display("FAIL err_type_avail: got %0d want 20", credits_available); end
        checks++; if (limit_error !== 1'b0) begin errors++; $display("FAIL err_type_limit: got %b want 0", limit_error); end
        drive(0, 0, 1, 3'd0, 10);
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (limit_error !== 1'b1) begin errors++; $display("FAIL err_limit: got %b want 1", limit_error); end
        checks++; if (credits_available !== 8'd20) begin errors++; $display("FAIL err_limit_avail: got %0d want 20", credits_available); end
        checks++; if (type_error !== 1'b1) begin errors++; $display("FAIL err_type_sticky: got %b want 1", type_error); end
        rst = 1'b1;
        drive(1, 1, 0, 3'd0, 0);
        tick();
        checks++; if ({type_error, limit_error, fc_init_done, fc_infinite, fc_timeout} !== 5'b0) begin errors++; $display("FAIL err_reset_flags: got %b want 00000", {type_error, limit_error, fc_init_done, fc_infinite, fc_timeout}); end
        checks++; if (tlp_ready !== 1'b0 || credits_available !== 8'd0) begin errors++; $display("FAIL err_reset_ready: got %b/%0d want 0/0", tlp_ready, credits_available); end
        rst = 1'b0;
        drive(0, 0, 0, 3'd0, 0);
    endtask

    task automatic test_infinite();
        pulse_reset();
        drive(0, 0, 1, 3'd0, 0);
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (fc_infinite !== 1'b1 || fc_init_done !== 1'b1) begin errors++; $display("FAIL inf_flags: got %b%b want 11", fc_infinite, fc_init_done); end
        checks++; if (credits_available !== 8'd255) begin errors++; $display("FAIL inf_avail: got %0d want 255", credits_available); end
        for (int i = 0; i < 300; i++) begin
            drive(1, 15, 0, 3'd0, 0);
            checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL inf_ready[%0d]: got %b want 1", i, tlp_ready); end
            tick();
        end
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (credits_consumed !== 8'd148) begin errors++; $display("FAIL inf_consumed: got %0d want 148", credits_consumed); end
        drive(0, 0, 1, 3'd0, 5);
        tick();
        drive(1, 15, 0, 3'd0, 0);
        checks++; if (fc_infinite !== 1'b1 || limit_error !== 1'b0) begin errors++; $display("FAIL inf_late_update: got inf %b lerr %b want 1 0", fc_infinite, limit_error); end
        checks++; if (tlp_ready !== 1'b1 || credits_available !== 8'd255) begin errors++; $display("FAIL inf_after_update: got %b/%0d want 1/255", tlp_ready, credits_available); end
        drive(0, 0, 0, 3'd0, 0);
    endtask

    task automatic test_timeout();
        pulse_reset();
        drive(0, 0, 1, 3'd0, 10);
        tick();
        drive(1, 10, 0, 3'd0, 0);
        checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL tmo_fill_ready: got %b want 1", tlp_ready); end
        tick();
        drive(1, 1, 0, 3'd0, 0);
        for (int i = 0; i < TMO; i++) begin
            checks++; if (fc_timeout !== 1'b0 || tlp_ready !== 1'b0) begin errors++; $display("FAIL tmo_early[%0d]: got to %b rdy %b want 0 0", i, fc_timeout, tlp_ready); end
            tick();
        end
        checks++; if (fc_timeout !== 1'b1) begin errors++; $display("FAIL tmo_reached: got %b want 1", fc_timeout); end
        repeat (5) tick();
        checks++; if (fc_timeout !== 1'b1) begin errors++; $display("FAIL tmo_saturate: got %b want 1", fc_timeout); end
        drive(1, 1, 1, 3'd0, 11);
        checks++; if (tlp_ready !== 1'b0) begin errors++; $display("FAIL tmo_upd_cycle: got %b want 0", tlp_ready); end
        tick();
        drive(1, 1, 0, 3'd0, 0);
        checks++; if (fc_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", fc_timeout); end
        checks++; if (tlp_ready !== 1'b1) begin errors++; $display("FAIL tmo_accept: got %b want 1", tlp_ready); end
        tick();
        drive(0, 0, 0, 3'd0, 0);
        checks++; if (credits_consumed !== 8'd11) begin errors++; $display("FAIL tmo_consumed: got %0d want 11", credits_consumed); end
    endtask

    task automatic test_random();
        bit hold, v, uv;
        int c, ul;
        logic [2:0] ut;
        pulse_reset();
        hold = 0; v = 0; c = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (!hold || $urandom_range(0, 63) == 0) begin
                v = ($urandom_range(0, 3) != 0);
                c = $urandom_range(0, 15);
            end
            uv = ($urandom_range(0, 5) == 0);
            ut = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            if (!m_active)                   ul = $urandom_range(1, 60);
            else if ($urandom_range(0, 9) == 0) ul = $urandom_range(0, 255);
            else                             ul = (m_limit + $urandom_range(0, 24)) & (MOD - 1);
            drive(v, c, uv, ut, ul);
            checks++; if (tlp_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, tlp_ready, m_ready()); end
            checks++; if (credits_consumed !== 8'(m_cons)) begin errors++; $display("FAIL rnd_consumed@%0d: got %0d want %0d", cyc, credits_consumed, m_cons); end
            checks++; if (credits_available !== 8'(m_avail())) begin errors++; $display("FAIL rnd_avail@%0d: got %0d want %0d", cyc, credits_available, m_avail()); end
            checks++; if ({fc_init_done, fc_infinite} !== {m_active, m_inf}) begin errors++; $display("FAIL rnd_state@%0d: got %b%b want %b%b", cyc, fc_init_done, fc_infinite, m_active, m_inf); end
            checks++; if ({type_error, limit_error} !== {m_type_err, m_limit_err}) begin errors++; $display("FAIL rnd_errflags@%0d: got %b%b want %b%b", cyc, type_error, limit_error, m_type_err, m_limit_err); end
            checks++; if (fc_timeout !== (m_cnt == TMO)) begin errors++; $display("FAIL rnd_timeout@%0d: got %b want %b", cyc, fc_timeout, (m_cnt == TMO)); end
            hold = v && !m_ready() && !rst;
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 3'd0, 0);
    endtask

    initial begin
        rst = 1'b1;
        tlp_valid = 1'b0;
        tlp_credits = '0;
        fc_update_valid = 1'b0;
        credit_limit = '0;
        m_active = 0; m_inf = 0; m_type_err = 0; m_limit_err = 0;
        m_limit = 0; m_cons = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_limit_update();
        test_wrap();
        test_errors();
        test_infinite();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
